// File: rtl/cond_unit_if.sv
// rtl/cond_unit_if.sv - instruction and result signals of the condition stage
interface cond_unit_if;
    logic       in_valid;
    logic       stall;
    logic [3:0] cond;
    logic [3:0] alu_flags;
    logic [1:0] flag_w;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       no_write;

    logic       out_valid;
    logic       pc_src;
    logic       reg_write;
    logic       mem_write;
    logic       cond_ex;
    logic [3:0] flags;
    logic [7:0] skip_count;

    modport master (
        output in_valid, stall, cond, alu_flags, flag_w, pcs, reg_w, mem_w, no_write,
        input  out_valid, pc_src, reg_write, mem_write, cond_ex, flags, skip_count
    );

    modport slave (
        input  in_valid, stall, cond, alu_flags, flag_w, pcs, reg_w, mem_w, no_write,
        output out_valid, pc_src, reg_write, mem_write, cond_ex, flags, skip_count
    );
endinterface

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - condition check, flag register and gated write enables
module cond_unit (
    input logic        clk,
    input logic        reset,
    cond_unit_if.slave bus
);
    logic [3:0] flags_q;
    logic [7:0] skip_q;
    logic       out_valid_q;
    logic       cond_ex_q;
    logic       pc_src_q;
    logic       reg_write_q;
    logic       mem_write_q;
    logic       n, z, c, v;
    logic       pass;

    // Evaluated against the registered flags only, so a setter followed
    // directly by a consumer needs no bypass from alu_flags.
    assign {n, z, c, v} = flags_q;

    always_comb begin
        pass = 1'b1;
        case (bus.cond)
            4'b0000: pass = z;
            4'b0001: pass = !z;
            4'b0010: pass = c;
            4'b0011: pass = !c;
            4'b0100: pass = n;
            4'b0101: pass = !n;
            4'b0110: pass = v;
            4'b0111: pass = !v;
            4'b1000: pass = c & !z;
            4'b1001: pass = !c | z;
            4'b1010: pass = (n == v);
            4'b1011: pass = (n != v);
            4'b1100: pass = !z & (n == v);
            4'b1101: pass = z | (n != v);
            default: pass = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q     <= 4'b0000;
            skip_q      <= 8'd0;
            out_valid_q <= 1'b0;
            cond_ex_q   <= 1'b0;
            pc_src_q    <= 1'b0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
        end else if (!bus.stall) begin
            if (bus.in_valid) begin
                out_valid_q <= 1'b1;
                cond_ex_q   <= pass;
                pc_src_q    <= bus.pcs & pass;
                reg_write_q <= bus.reg_w & pass & !bus.no_write;
                mem_write_q <= bus.mem_w & pass;
                if (pass) begin
                    if (bus.flag_w[1]) flags_q[3:2] <= bus.alu_flags[3:2];
                    if (bus.flag_w[0]) flags_q[1:0] <= bus.alu_flags[1:0];
                end else if (skip_q != 8'hFF) begin
                    skip_q <= skip_q + 8'd1;
                end
            end else begin
                out_valid_q <= 1'b0;
                cond_ex_q   <= 1'b0;
                pc_src_q    <= 1'b0;
                reg_write_q <= 1'b0;
                mem_write_q <= 1'b0;
            end
        end
    end

    assign bus.flags      = flags_q;
    assign bus.skip_count = skip_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.cond_ex    = cond_ex_q;
    assign bus.pc_src     = pc_src_q;
    assign bus.reg_write  = reg_write_q;
    assign bus.mem_write  = mem_write_q;
endmodule
